pipeid_hzp: RTL and testbench

- Parametrised next-generation decode stage of the 5-stage MIPS-subset pipeline.
- Owns the IF/ID pipeline latch and the register file with a same-cycle write-through bypass. Both sit on the single rising clock edge.
- Decodes the instruction, forwards operands from EXE/MEM and resolves branches in ID.
- Adds a selectable RAW interlock mode, an optional branch-delay-slot flush and a saturating stall counter.

---
 rtl/pipeid_hzp.sv | 220 ++++++++++++++++++++++
 tb/tb_pipeid_hzp.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeid_hzp.sv
// Decode stage of the 5-stage MIPS-subset pipeline: IF/ID latch, register file with
// write-through bypass, operand forwarding, RAW interlock, branch resolution, stall counter.
module pipeid_hzp #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FWD_EN     = 1,
    parameter int DELAY_SLOT = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [XLEN-1:0] fpc4,
    input  logic [31:0]     finst,
    input  logic            fvalid,
    input  logic [4:0]      ern,
    input  logic [4:0]      mrn,
    input  logic [4:0]      wrn,
    input  logic            ewreg,
    input  logic            mwreg,
    input  logic            wwreg,
    input  logic            em2reg,
    input  logic            mm2reg,
    input  logic [XLEN-1:0] ealu,
    input  logic [XLEN-1:0] malu,
    input  logic [XLEN-1:0] mmo,
    input  logic [XLEN-1:0] wdi,
    output logic            dvalid,
    output logic            nostall,
    output logic [1:0]      pcsource,
    output logic [XLEN-1:0] bpc,
    output logic [XLEN-1:0] jpc,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rn,
    output logic [3:0]      aluc,
    output logic            wreg,
    output logic            m2reg,
    output logic            wmem,
    output logic            aluimm,
    output logic            shift,
    output logic            jal,
    output logic [15:0]     stall_cnt
);

    logic [31:0]     inst;
    logic [XLEN-1:0] dpc4;
    logic            valid;
    logic [XLEN-1:0] regs [NREG];
    logic [15:0]     cnt;
    logic            stall;
    logic            active;

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_sa;

    assign op        = inst[31:26];
    assign func      = inst[5:0];
    assign rs        = inst[25:21];
    assign rt        = inst[20:16];
    assign rd        = inst[15:11];
    assign unused_sa = ^inst[10:6];

    logic [3:0] dec_aluc;
    logic dec_wreg, dec_m2reg, dec_wmem, dec_aluimm, dec_shift, dec_jal;
    logic dec_sext, dec_rdst, use_rs, use_rt, is_beq, is_bne, is_jr, is_jmp;

    // Unrecognised encodings leave every control at its default, i.e. a nop.
    always_comb begin
        dec_aluc   = 4'b0000;
        dec_wreg   = 1'b0;
        dec_m2reg  = 1'b0;
        dec_wmem   = 1'b0;
        dec_aluimm = 1'b0;
        dec_shift  = 1'b0;
        dec_jal    = 1'b0;
        dec_sext   = 1'b0;
        dec_rdst   = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jr      = 1'b0;
        is_jmp     = 1'b0;
        if (op == 6'h00) begin
            dec_rdst = 1'b1;
            case (func)
                6'h20: begin dec_wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                6'h22: begin dec_wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = 4'b0100; end
                6'h24: begin dec_wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = 4'b0001; end
                6'h25: begin dec_wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = 4'b0101; end
                6'h26: begin dec_wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = 4'b0010; end
                6'h00: begin dec_wreg = 1'b1; use_rt = 1'b1; dec_shift = 1'b1; dec_aluc = 4'b0011; end
                6'h02: begin dec_wreg = 1'b1; use_rt = 1'b1; dec_shift = 1'b1; dec_aluc = 4'b0111; end
                6'h03: begin dec_wreg = 1'b1; use_rt = 1'b1; dec_shift = 1'b1; dec_aluc = 4'b1111; end
                6'h08: begin use_rs = 1'b1; is_jr = 1'b1; end
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: begin dec_wreg = 1'b1; use_rs = 1'b1; dec_aluimm = 1'b1; dec_sext = 1'b1; end
                6'h0C: begin dec_wreg = 1'b1; use_rs = 1'b1; dec_aluimm = 1'b1; dec_aluc = 4'b0001; end
                6'h0D: begin dec_wreg = 1'b1; use_rs = 1'b1; dec_aluimm = 1'b1; dec_aluc = 4'b0101; end
                6'h0E: begin dec_wreg = 1'b1; use_rs = 1'b1; dec_aluimm = 1'b1; dec_aluc = 4'b0010; end
                6'h23: begin
                    dec_wreg = 1'b1; dec_m2reg = 1'b1; use_rs = 1'b1; dec_aluimm = 1'b1; dec_sext = 1'b1;
                end
                6'h2B: begin
                    dec_wmem = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluimm = 1'b1; dec_sext = 1'b1;
                end
                6'h04: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_sext = 1'b1; dec_aluc = 4'b0100; end
                6'h05: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_sext = 1'b1; dec_aluc = 4'b0100; end
                6'h0F: begin dec_wreg = 1'b1; dec_aluimm = 1'b1; dec_aluc = 4'b0110; end
                6'h02: begin is_jmp = 1'b1; end
                6'h03: begin is_jmp = 1'b1; dec_jal = 1'b1; dec_wreg = 1'b1; end
                default: ;
            endcase
        end
    end

    logic [XLEN-1:0] rf_a, rf_b;
    logic            wr_ok;

    assign wr_ok = wwreg && (wrn != 5'd0) && (int'(wrn) < NREG);

    // The WB write lands on the same edge, so a same-cycle read sees wdi directly.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs == i[4:0]) rf_a = regs[i];
            if (rt == i[4:0]) rf_b = regs[i];
        end
        if (wr_ok && wrn == rs) rf_a = wdi;
        if (wr_ok && wrn == rt) rf_b = wdi;
    end

    logic e_hit_a, e_hit_b, m_hit_a, m_hit_b, haz_a, haz_b;

    assign e_hit_a = ewreg && (ern != 5'd0) && (ern == rs);
    assign e_hit_b = ewreg && (ern != 5'd0) && (ern == rt);
    assign m_hit_a = mwreg && (mrn != 5'd0) && (mrn == rs);
    assign m_hit_b = mwreg && (mrn != 5'd0) && (mrn == rt);

    always_comb begin
        a = rf_a;
        b = rf_b;
        if (FWD_EN != 0) begin
            if (e_hit_a && !em2reg) a = ealu;
            else if (m_hit_a)       a = mm2reg ? mmo : malu;
            if (e_hit_b && !em2reg) b = ealu;
            else if (m_hit_b)       b = mm2reg ? mmo : malu;
        end
    end

    // With forwarding only a load still in EXE cannot be bypassed.
    assign haz_a  = use_rs && ((FWD_EN != 0) ? (e_hit_a && em2reg) : (e_hit_a || m_hit_a));
    assign haz_b  = use_rt && ((FWD_EN != 0) ? (e_hit_b && em2reg) : (e_hit_b || m_hit_b));
    assign stall  = valid && (haz_a || haz_b);
    assign active = valid && !stall;

    always_comb begin
        pcsource = 2'b00;
        if (active) begin
            if ((is_beq && a == b) || (is_bne && a != b)) pcsource = 2'b01;
            else if (is_jr)                                pcsource = 2'b10;
            else if (is_jmp)                               pcsource = 2'b11;
        end
    end

    assign dvalid    = valid;
    assign nostall   = !stall;
    assign wreg      = active && dec_wreg;
    assign m2reg     = active && dec_m2reg;
    assign wmem      = active && dec_wmem;
    assign jal       = active && dec_jal;
    assign aluc      = dec_aluc;
    assign aluimm    = dec_aluimm;
    assign shift     = dec_shift;
    assign rn        = dec_jal ? 5'd31 : (dec_rdst ? rd : rt);
    assign imm       = dec_sext ? {{(XLEN-16){inst[15]}}, inst[15:0]} : {{(XLEN-16){1'b0}}, inst[15:0]};
    assign bpc       = dpc4 + (imm << 2);
    assign jpc       = {dpc4[XLEN-1:28], inst[25:0], 2'b00};
    assign stall_cnt = cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inst  <= '0;
            dpc4  <= '0;
            valid <= 1'b0;
        end else if (nostall) begin
            if (pcsource != 2'b00 && DELAY_SLOT == 0) begin
                valid <= 1'b0;
            end else begin
                inst  <= finst;
                dpc4  <= fpc4;
                valid <= fvalid;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            for (int i = 1; i < NREG; i++) begin
                if (wrn == i[4:0]) regs[i] <= wdi;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                         cnt <= 16'd0;
        else if (stall && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end

endmodule

// File: tb/tb_pipeid_hzp.sv
// Randomised bench for pipeid_hzp: two configurations share one stimulus stream and are
// checked against a mnemonic-level reference model through per-configuration expected queues.
module tb_pipeid_hzp;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] fpc4, ealu, malu, mmo, wdi;
    logic [31:0] finst;
    logic        fvalid;
    logic [4:0]  ern, mrn, wrn;
    logic        ewreg, mwreg, wwreg, em2reg, mm2reg;

    always #5 clk = ~clk;

    logic        d0_dvalid, d0_nostall, d0_wreg, d0_m2reg, d0_wmem, d0_aluimm, d0_shift, d0_jal;
    logic [1:0]  d0_pcsource;
    logic [31:0] d0_bpc, d0_jpc, d0_a, d0_b, d0_imm;
    logic [4:0]  d0_rn;
    logic [3:0]  d0_aluc;
    logic [15:0] d0_cnt;

    logic        d1_dvalid, d1_nostall, d1_wreg, d1_m2reg, d1_wmem, d1_aluimm, d1_shift, d1_jal;
    logic [1:0]  d1_pcsource;
    logic [63:0] d1_bpc, d1_jpc, d1_a, d1_b, d1_imm;
    logic [4:0]  d1_rn;
    logic [3:0]  d1_aluc;
    logic [15:0] d1_cnt;

    pipeid_hzp #(.XLEN(32), .NREG(32), .FWD_EN(1), .DELAY_SLOT(1)) dut0 (
        .clk(clk), .clr(clr), .fpc4(fpc4[31:0]), .finst(finst), .fvalid(fvalid),
        .ern(ern), .mrn(mrn), .wrn(wrn), .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg),
        .em2reg(em2reg), .mm2reg(mm2reg), .ealu(ealu[31:0]), .malu(malu[31:0]),
        .mmo(mmo[31:0]), .wdi(wdi[31:0]), .dvalid(d0_dvalid), .nostall(d0_nostall),
        .pcsource(d0_pcsource), .bpc(d0_bpc), .jpc(d0_jpc), .a(d0_a), .b(d0_b), .imm(d0_imm),
        .rn(d0_rn), .aluc(d0_aluc), .wreg(d0_wreg), .m2reg(d0_m2reg), .wmem(d0_wmem),
        .aluimm(d0_aluimm), .shift(d0_shift), .jal(d0_jal), .stall_cnt(d0_cnt)
    );

    pipeid_hzp #(.XLEN(64), .NREG(16), .FWD_EN(0), .DELAY_SLOT(0)) dut1 (
        .clk(clk), .clr(clr), .fpc4(fpc4), .finst(finst), .fvalid(fvalid),
        .ern(ern), .mrn(mrn), .wrn(wrn), .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg),
        .em2reg(em2reg), .mm2reg(mm2reg), .ealu(ealu), .malu(malu),
        .mmo(mmo), .wdi(wdi), .dvalid(d1_dvalid), .nostall(d1_nostall),
        .pcsource(d1_pcsource), .bpc(d1_bpc), .jpc(d1_jpc), .a(d1_a), .b(d1_b), .imm(d1_imm),
        .rn(d1_rn), .aluc(d1_aluc), .wreg(d1_wreg), .m2reg(d1_m2reg), .wmem(d1_wmem),
        .aluimm(d1_aluimm), .shift(d1_shift), .jal(d1_jal), .stall_cnt(d1_cnt)
    );

    typedef enum int {
        M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR,
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE, M_LUI, M_J, M_JAL, M_UNDEF
    } mn_t;

    typedef struct {
        logic        dvalid, nostall, stall, defd;
        logic [1:0]  pcsource;
        logic [63:0] bpc, jpc, a, b, imm;
        logic [4:0]  rn;
        logic [3:0]  aluc;
        logic        wreg, m2reg, wmem, aluimm, shift, jal;
        logic [15:0] cnt;
    } resp_t;

    resp_t exp_q0[$];
    resp_t exp_q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    int cfg_x[2] = '{32, 64};
    int cfg_n[2] = '{32, 16};
    int cfg_f[2] = '{1, 0};
    int cfg_d[2] = '{1, 0};

    logic [63:0] m_pc4  [2];
    logic [31:0] m_inst [2];
    logic        m_valid[2];
    logic [63:0] m_rf   [2][32];
    int          m_cnt  [2];

    function automatic logic [63:0] xm(input int c);
        return (cfg_x[c] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic mn_t classify(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
                6'h25: return M_OR;   6'h26: return M_XOR;  6'h00: return M_SLL;
                6'h02: return M_SRL;  6'h03: return M_SRA;  6'h08: return M_JR;
                default: return M_UNDEF;
            endcase
        end
        case (op)
            6'h08: return M_ADDI; 6'h0C: return M_ANDI; 6'h0D: return M_ORI;
            6'h0E: return M_XORI; 6'h23: return M_LW;   6'h2B: return M_SW;
            6'h04: return M_BEQ;  6'h05: return M_BNE;  6'h0F: return M_LUI;
            6'h02: return M_J;    6'h03: return M_JAL;
            default: return M_UNDEF;
        endcase
    endfunction

    function automatic logic [31:0] encode(input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] im,
                                           input logic [25:0] tg);
        case (m)
            M_ADD:  return {6'h00, rs, rt, rd, tg[4:0], 6'h20};
            M_SUB:  return {6'h00, rs, rt, rd, tg[4:0], 6'h22};
            M_AND:  return {6'h00, rs, rt, rd, tg[4:0], 6'h24};
            M_OR:   return {6'h00, rs, rt, rd, tg[4:0], 6'h25};
            M_XOR:  return {6'h00, rs, rt, rd, tg[4:0], 6'h26};
            M_SLL:  return {6'h00, rs, rt, rd, tg[4:0], 6'h00};
            M_SRL:  return {6'h00, rs, rt, rd, tg[4:0], 6'h02};
            M_SRA:  return {6'h00, rs, rt, rd, tg[4:0], 6'h03};
            M_JR:   return {6'h00, rs, 15'd0, 6'h08};
            M_ADDI: return {6'h08, rs, rt, im};
            M_ANDI: return {6'h0C, rs, rt, im};
            M_ORI:  return {6'h0D, rs, rt, im};
            M_XORI: return {6'h0E, rs, rt, im};
            M_LW:   return {6'h23, rs, rt, im};
            M_SW:   return {6'h2B, rs, rt, im};
            M_BEQ:  return {6'h04, rs, rt, im};
            M_BNE:  return {6'h05, rs, rt, im};
            M_LUI:  return {6'h0F, 5'd0, rt, im};
            M_J:    return {6'h02, tg};
            M_JAL:  return {6'h03, tg};
            default: return im[0] ? {6'h3F, rs, rt, im} : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
        endcase
    endfunction

    function automatic logic [63:0] rd_reg(input int c, input logic [4:0] r);
        if (r == 5'd0 || int'(r) >= cfg_n[c]) return 64'd0;
        if (wwreg && wrn == r) return wdi & xm(c);
        return m_rf[c][r];
    endfunction

    function automatic logic [63:0] fwd(input int c, input logic [4:0] r);
        if (cfg_f[c] != 0) begin
            if (ewreg && !em2reg && ern != 5'd0 && ern == r) return ealu & xm(c);
            if (mwreg && mrn != 5'd0 && mrn == r) return (mm2reg ? mmo : malu) & xm(c);
        end
        return rd_reg(c, r);
    endfunction

    function automatic logic hazard(input int c, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (cfg_f[c] != 0) return ewreg && em2reg && ern == r;
        return (ewreg && ern == r) || (mwreg && mrn == r);
    endfunction

    function automatic resp_t predict(input int c);
        resp_t e;
        mn_t   m;
        logic [31:0] ins;
        logic  r_rs, r_rt, w_rd, w_rt, act;
        ins  = m_inst[c];
        m    = classify(ins);
        r_rs = m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_JR, M_ADDI, M_ANDI, M_ORI, M_XORI,
                         M_LW, M_SW, M_BEQ, M_BNE};
        r_rt = m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SW, M_BEQ, M_BNE};
        w_rd = m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA};
        w_rt = m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_LUI};
        e.dvalid  = m_valid[c];
        e.cnt     = m_cnt[c][15:0];
        e.defd    = (m != M_UNDEF);
        e.stall   = m_valid[c] && ((r_rs && hazard(c, ins[25:21])) || (r_rt && hazard(c, ins[20:16])));
        e.nostall = !e.stall;
        e.a       = fwd(c, ins[25:21]);
        e.b       = fwd(c, ins[20:16]);
        if (m inside {M_ADDI, M_LW, M_SW, M_BEQ, M_BNE})
            e.imm = {{48{ins[15]}}, ins[15:0]} & xm(c);
        else
            e.imm = {48'd0, ins[15:0]};
        e.bpc = (m_pc4[c] + (e.imm << 2)) & xm(c);
        e.jpc = ((m_pc4[c] & ~64'h0FFF_FFFF) | {36'd0, ins[25:0], 2'b00}) & xm(c);
        act = m_valid[c] && !e.stall;
        e.pcsource = 2'b00;
        if (act) begin
            if (m == M_BEQ && e.a == e.b)        e.pcsource = 2'b01;
            else if (m == M_BNE && e.a != e.b)   e.pcsource = 2'b01;
            else if (m == M_JR)                  e.pcsource = 2'b10;
            else if (m == M_J || m == M_JAL)     e.pcsource = 2'b11;
        end
        e.wreg   = act && (w_rd || w_rt || m == M_JAL);
        e.m2reg  = act && (m == M_LW);
        e.wmem   = act && (m == M_SW);
        e.jal    = act && (m == M_JAL);
        e.aluimm = m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_LUI};
        e.shift  = m inside {M_SLL, M_SRL, M_SRA};
        if (m == M_JAL)                                  e.rn = 5'd31;
        else if (m inside {w_rd ? m : M_UNDEF, M_JR})    e.rn = ins[15:11];
        else                                             e.rn = ins[20:16];
        case (m)
            M_SUB, M_BEQ, M_BNE: e.aluc = 4'b0100;
            M_AND, M_ANDI:       e.aluc = 4'b0001;
            M_OR, M_ORI:         e.aluc = 4'b0101;
            M_XOR, M_XORI:       e.aluc = 4'b0010;
            M_LUI:               e.aluc = 4'b0110;
            M_SLL:               e.aluc = 4'b0011;
            M_SRL:               e.aluc = 4'b0111;
            M_SRA:               e.aluc = 4'b1111;
            default:             e.aluc = 4'b0000;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pc4[c] = 64'd0; m_inst[c] = 32'd0; m_valid[c] = 1'b0; m_cnt[c] = 0;
            for (int r = 0; r < 32; r++) m_rf[c][r] = 64'd0;
        end
    endtask

    task automatic model_step(input int c, input resp_t e);
        if (wwreg && wrn != 5'd0 && int'(wrn) < cfg_n[c]) m_rf[c][wrn] = wdi & xm(c);
        if (e.stall && m_cnt[c] < 65535) m_cnt[c]++;
        if (e.nostall) begin
            if (e.pcsource != 2'b00 && cfg_d[c] == 0) begin
                m_valid[c] = 1'b0;
            end else begin
                m_pc4[c] = fpc4 & xm(c); m_inst[c] = finst; m_valid[c] = fvalid;
            end
        end
    endtask

    task automatic chk(input int c, input string name, input logic [63:0] act, input logic [63:0] e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %h expected %h at %0t", c, name, act, e, $time);
        end
    endtask

    task automatic compare(input int c, input resp_t act, input resp_t e);
        chk(c, "dvalid", 64'(act.dvalid), 64'(e.dvalid));
        chk(c, "nostall", 64'(act.nostall), 64'(e.nostall));
        chk(c, "pcsource", 64'(act.pcsource), 64'(e.pcsource));
        chk(c, "wreg", 64'(act.wreg), 64'(e.wreg));
        chk(c, "m2reg", 64'(act.m2reg), 64'(e.m2reg));
        chk(c, "wmem", 64'(act.wmem), 64'(e.wmem));
        chk(c, "jal", 64'(act.jal), 64'(e.jal));
        chk(c, "stall_cnt", 64'(act.cnt), 64'(e.cnt));
        if (e.dvalid) begin
            chk(c, "a", act.a, e.a);
            chk(c, "b", act.b, e.b);
            chk(c, "imm", act.imm, e.imm);
            chk(c, "bpc", act.bpc, e.bpc);
            chk(c, "jpc", act.jpc, e.jpc);
            if (e.defd) begin
                chk(c, "rn", 64'(act.rn), 64'(e.rn));
                chk(c, "aluc", 64'(act.aluc), 64'(e.aluc));
                chk(c, "aluimm", 64'(act.aluimm), 64'(e.aluimm));
                chk(c, "shift", 64'(act.shift), 64'(e.shift));
            end
        end
    endtask

    // Monitor: consumes one expected response per configuration at each falling edge.
    always @(negedge clk) begin
        resp_t act, e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            act.dvalid = d0_dvalid; act.nostall = d0_nostall; act.pcsource = d0_pcsource;
            act.bpc = {32'd0, d0_bpc}; act.jpc = {32'd0, d0_jpc}; act.a = {32'd0, d0_a};
            act.b = {32'd0, d0_b}; act.imm = {32'd0, d0_imm}; act.rn = d0_rn; act.aluc = d0_aluc;
            act.wreg = d0_wreg; act.m2reg = d0_m2reg; act.wmem = d0_wmem; act.aluimm = d0_aluimm;
            act.shift = d0_shift; act.jal = d0_jal; act.cnt = d0_cnt; act.stall = 1'b0; act.defd = 1'b0;
            compare(0, act, e);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            act.dvalid = d1_dvalid; act.nostall = d1_nostall; act.pcsource = d1_pcsource;
            act.bpc = d1_bpc; act.jpc = d1_jpc; act.a = d1_a; act.b = d1_b; act.imm = d1_imm;
            act.rn = d1_rn; act.aluc = d1_aluc; act.wreg = d1_wreg; act.m2reg = d1_m2reg;
            act.wmem = d1_wmem; act.aluimm = d1_aluimm; act.shift = d1_shift; act.jal = d1_jal;
            act.cnt = d1_cnt; act.stall = 1'b0; act.defd = 1'b0;
            compare(1, act, e);
        end
    end

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 9) == 0) ? 5'd20 : 5'($urandom_range(0, 7));
    endfunction

    task automatic drive_random();
        mn_t m;
        m      = ($urandom_range(0, 19) == 0) ? M_UNDEF : mn_t'($urandom_range(0, 19));
        finst  = encode(m, pick_reg(), pick_reg(), pick_reg(), 16'($urandom), 26'($urandom));
        fpc4   = {$urandom, $urandom};
        fvalid = ($urandom_range(0, 6) != 0);
        ern    = pick_reg(); mrn = pick_reg(); wrn = pick_reg();
        ewreg  = $urandom_range(0, 1) == 1; mwreg = $urandom_range(0, 1) == 1;
        wwreg  = $urandom_range(0, 2) != 0;
        em2reg = $urandom_range(0, 1) == 1; mm2reg = $urandom_range(0, 1) == 1;
        ealu   = {$urandom, $urandom}; malu = {$urandom, $urandom};
        mmo    = {$urandom, $urandom}; wdi  = {$urandom, $urandom};
    endtask

    initial begin
        resp_t e0, e1;
        logic  do_rst, last_stall;
        int    n_rst;
        clr = 1'b1;
        drive_random();
        model_reset();
        last_stall = 1'b0;
        n_rst = 0;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            do_rst = (cyc == 0) ||
                     (cyc > 100 && last_stall && n_rst < 4 && $urandom_range(0, 3) == 0);
            clr = do_rst;
            if (do_rst) begin
                n_rst++;
                model_reset();
            end
            e0 = predict(0);
            e1 = predict(1);
            exp_q0.push_back(e0);
            exp_q1.push_back(e1);
            last_stall = e0.stall;
            @(posedge clk);
            if (!do_rst) begin
                model_step(0, e0);
                model_step(1, e1);
            end
            #1;
        end
        clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk(0, "queue_drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
